// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Widths that depend on instance parameters are derived through the helper function.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // Widths for the default build (NUM_REQ=4, MAX_BURST=4)
    localparam int IDX_W = $clog2(4);
    localparam int CNT_W = cnt_width(4);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request scanning from
// i_start upward, wrapping modulo N by compare so non-power-of-2 N works.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    logic [IW:0]  w_cand [N];
    logic [N-1:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] w_sum;
            assign w_sum       = {1'b0, i_start} + (IW+1)'(gi);
            assign w_cand[gi]  = (w_sum >= (IW+1)'(N)) ? (w_sum - (IW+1)'(N)) : w_sum;
            assign w_hit[gi]   = i_req[w_cand[gi][IW-1:0]];
        end
    endgenerate

    // Scan from the far end so the smallest offset from i_start wins.
    always_comb begin
        o_found = |w_hit;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_idx = w_cand[k][IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port between NUM_REQ producers.
// A grant is held for a burst that ends on req_last or after MAX_BURST beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(MAX_BURST);

    state_e          r_state;
    logic [GW-1:0]   r_rr_ptr;
    logic [GW-1:0]   r_grant_id;
    logic [CW-1:0]   r_beat_cnt;

    logic            w_found;
    logic [GW-1:0]   w_pick;
    logic            w_locked;
    logic            w_can_accept;
    logic            w_xfer;
    logic            w_burst_end;
    logic [GW-1:0]   w_next_ptr;
    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

    rr_pick #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_pick (
        .i_req   (req_valid),
        .i_start (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // Reset gates the handshake so a beat offered in the reset cycle is not consumed.
    assign w_locked     = (r_state == ST_LOCKED);
    assign w_can_accept = w_locked && !rst && !fifo_full;
    assign w_xfer       = w_can_accept && req_valid[r_grant_id];
    assign w_burst_end  = w_xfer && (req_last[r_grant_id] || (r_beat_cnt == CW'(MAX_BURST - 1)));
    assign w_next_ptr   = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : (r_grant_id + 1'b1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign w_slice[gi]   = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = w_can_accept && (r_grant_id == GW'(gi));
        end
    endgenerate

    assign fifo_wr_en   = w_xfer;
    assign fifo_data_in = w_locked ? w_slice[r_grant_id] : '0;
    assign grant_id     = r_grant_id;
    assign busy         = w_locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    // An idle granted producer keeps the lock so packets stay contiguous.
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                    if (w_burst_end) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a 16-deep FIFO model behind the DUT, a write/read
// scoreboard, table-driven cycle vectors and hand-written corner sequences.
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        fifo_full, fifo_wr_en, busy;
    logic [7:0]  fifo_data_in;
    logic [1:0]  grant_id;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .grant_id(grant_id), .busy(busy)
    );

    logic [2:0]  v3, l3, ready3;
    logic [23:0] d3;
    logic        full3, wr3, busy3;
    logic [7:0]  fd3;
    logic [1:0]  g3;

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(4)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_data(d3),
        .req_last(l3), .req_ready(ready3), .fifo_full(full3),
        .fifo_wr_en(wr3), .fifo_data_in(fd3),
        .grant_id(g3), .busy(busy3)
    );

    // Showahead sync FIFO model, DEPTH=16
    logic [7:0] mem [16];
    logic [3:0] wp, rp;
    logic [4:0] cnt;
    logic       rd_en, wr_ok, rd_ok;
    logic [7:0] fifo_dout;

    assign fifo_full = (cnt == 5'd16);
    assign wr_ok     = fifo_wr_en && !fifo_full;
    assign rd_ok     = rd_en && (cnt != 5'd0);
    assign fifo_dout = mem[rp];

    always @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr_ok) begin
                mem[wp] <= fifo_data_in;
                wp      <= wp + 4'd1;
            end
            if (rd_ok) rp <= rp + 4'd1;
            cnt <= cnt + {4'd0, wr_ok} - {4'd0, rd_ok};
        end
    end

    logic [7:0] exp_q [$];
    logic [7:0] rb_q  [$];
    logic [8:0] pq [4][$];
    logic [3:0] hold, acc;
    bit         use_engine;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        busy;
        logic [1:0]  grant;
        logic        wr;
        logic [3:0]  ready;
        logic [7:0]  fd;
    } vec_t;

    typedef struct {
        logic [2:0] valid;
        logic       busy;
        logic [1:0] grant;
        logic       wr;
        logic [2:0] ready;
        logic [7:0] fd;
    } vec3_t;

    vec_t  tv  [8];
    vec3_t tv3 [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        if (use_engine) begin
            req_valid = '0;
            req_last  = '0;
            req_data  = '0;
            for (int i = 0; i < 4; i++) begin
                if (pq[i].size() != 0 && !hold[i]) begin
                    req_valid[i]       = 1'b1;
                    req_last[i]        = pq[i][0][8];
                    req_data[i*8 +: 8] = pq[i][0][7:0];
                end
            end
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        acc = req_valid & req_ready;
        if (fifo_wr_en) begin
            chk("wr_while_full", {31'd0, fifo_full}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: got %0h expected no write", fifo_data_in);
            end else begin
                e = exp_q.pop_front();
                $display("write %02h (expect %02h) grant %0d", fifo_data_in, e, grant_id);
                chk("wr_data", {24'd0, fifo_data_in}, {24'd0, e});
            end
        end
        if (rd_ok) begin
            if (rb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd: got %0h expected empty", fifo_dout);
            end else begin
                e = rb_q.pop_front();
                $display("read  %02h (expect %02h)", fifo_dout, e);
                chk("rd_data", {24'd0, fifo_dout}, {24'd0, e});
            end
        end
    endtask

    task automatic half();
        drive_inputs();
        @(negedge clk);
        monitor();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
        if (use_engine) begin
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) void'(pq[i].pop_front());
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            half();
            fin();
        end
    endtask

    task automatic do_reset();
        use_engine = 1'b1;
        rst   = 1'b1;
        rd_en = 1'b0;
        hold  = '0;
        v3    = '0;
        for (int i = 0; i < 4; i++) pq[i].delete();
        exp_q.delete();
        rb_q.delete();
        half();
        chk("rst_cycle_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        fin();
        rst = 1'b0;
        half();
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("rst_busy3", {31'd0, busy3}, 32'd0);
        fin();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0; req_last = '0; req_data = '0;
        v3 = '0; l3 = 3'b101; d3 = 24'hC2_00_B0; full3 = 1'b0;
        rd_en = 1'b0; hold = '0; acc = '0; rst = 1'b1;

        // Single producer, then a tie between 0 and 1 that rr_ptr=1 must resolve to 1
        tv[0] = '{4'b0001, 4'b0000, 32'h11,   1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tv[1] = '{4'b0001, 4'b0000, 32'h11,   1'b1, 2'd0, 1'b1, 4'b0001, 8'h11};
        tv[2] = '{4'b0001, 4'b0000, 32'h12,   1'b1, 2'd0, 1'b1, 4'b0001, 8'h12};
        tv[3] = '{4'b0001, 4'b0001, 32'h13,   1'b1, 2'd0, 1'b1, 4'b0001, 8'h13};
        tv[4] = '{4'b0000, 4'b0000, 32'h0,    1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tv[5] = '{4'b0011, 4'b0011, 32'h3121, 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};
        tv[6] = '{4'b0011, 4'b0011, 32'h3121, 1'b1, 2'd1, 1'b1, 4'b0010, 8'h31};
        tv[7] = '{4'b0000, 4'b0000, 32'h0,    1'b0, 2'd0, 1'b0, 4'b0000, 8'h00};

        tv3[0] = '{3'b100, 1'b0, 2'd0, 1'b0, 3'b000, 8'h00};
        tv3[1] = '{3'b100, 1'b1, 2'd2, 1'b1, 3'b100, 8'hC2};
        tv3[2] = '{3'b100, 1'b0, 2'd0, 1'b0, 3'b000, 8'h00};
        tv3[3] = '{3'b101, 1'b1, 2'd2, 1'b1, 3'b100, 8'hC2};
        tv3[4] = '{3'b101, 1'b0, 2'd0, 1'b0, 3'b000, 8'h00};
        tv3[5] = '{3'b101, 1'b1, 2'd0, 1'b1, 3'b001, 8'hB0};
        tv3[6] = '{3'b000, 1'b0, 2'd0, 1'b0, 3'b000, 8'h00};

        do_reset();

        use_engine = 1'b0;
        foreach (tv[n]) begin
            if (n == 1) begin
                exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
                exp_q.push_back(8'h31);
                rb_q.push_back(8'h11);  rb_q.push_back(8'h12);  rb_q.push_back(8'h13);
                rb_q.push_back(8'h31);
            end
            req_valid = tv[n].valid;
            req_last  = tv[n].last;
            req_data  = tv[n].data;
            half();
            chk($sformatf("t1_busy[%0d]", n), {31'd0, busy}, {31'd0, tv[n].busy});
            if (tv[n].busy) chk($sformatf("t1_grant[%0d]", n), {30'd0, grant_id}, {30'd0, tv[n].grant});
            chk($sformatf("t1_wr[%0d]", n), {31'd0, fifo_wr_en}, {31'd0, tv[n].wr});
            chk($sformatf("t1_ready[%0d]", n), {28'd0, req_ready}, {28'd0, tv[n].ready});
            chk($sformatf("t1_fd[%0d]", n), {24'd0, fifo_data_in}, {24'd0, tv[n].fd});
            fin();
        end
        rd_en = 1'b1;
        run(6);
        rd_en = 1'b0;
        chk("t1_wr_left", exp_q.size(), 0);
        chk("t1_rd_left", rb_q.size(), 0);

        // Round robin, all four producers streaming without last
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) pq[i].push_back({1'b0, 8'(i * 16 + k)});
        for (int h = 0; h < 2; h++)
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) begin
                    exp_q.push_back(8'(i * 16 + h * 4 + k));
                    rb_q.push_back(8'(i * 16 + h * 4 + k));
                end
        run(20);
        half();
        chk("rr_bubble_busy", {31'd0, busy}, 32'd0);
        chk("rr_fifo_count", {27'd0, cnt}, 32'd16);
        fin();
        half();
        chk("rr_regrant_busy",  {31'd0, busy}, 32'd1);
        chk("rr_regrant_id",    {30'd0, grant_id}, 32'd0);
        chk("rr_full_ready",    {28'd0, req_ready}, 32'd0);
        chk("rr_full_wr",       {31'd0, fifo_wr_en}, 32'd0);
        chk("rr_writes_left",   exp_q.size(), 16);
        fin();
        rd_en = 1'b1;
        run(50);
        rd_en = 1'b0;
        chk("rr_wr_left", exp_q.size(), 0);
        chk("rr_rd_left", rb_q.size(), 0);

        // Backpressure: 15 entries from producer 1, then producer 2 hits full
        do_reset();
        for (int k = 0; k < 15; k++) begin
            pq[1].push_back({(k == 14) ? 1'b1 : 1'b0, 8'(8'h40 + k)});
            exp_q.push_back(8'(8'h40 + k));
            rb_q.push_back(8'(8'h40 + k));
        end
        run(19);
        chk("bp_prefill", {27'd0, cnt}, 32'd15);
        pq[2].push_back({1'b0, 8'hA0}); pq[2].push_back({1'b0, 8'hA1}); pq[2].push_back({1'b1, 8'hA2});
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        rb_q.push_back(8'hA0);  rb_q.push_back(8'hA1);  rb_q.push_back(8'hA2);
        half();
        chk("bp_idle_busy", {31'd0, busy}, 32'd0);
        fin();
        half();
        chk("bp_first_grant", {30'd0, grant_id}, 32'd2);
        chk("bp_first_wr",    {31'd0, fifo_wr_en}, 32'd1);
        fin();
        half();
        chk("bp_full",       {31'd0, fifo_full}, 32'd1);
        chk("bp_ready_low",  {28'd0, req_ready}, 32'd0);
        chk("bp_no_wr",      {31'd0, fifo_wr_en}, 32'd0);
        chk("bp_hold_grant", {30'd0, grant_id}, 32'd2);
        fin();
        run(3);
        rd_en = 1'b1;
        run(2);
        rd_en = 1'b0;
        run(4);
        chk("bp_wr_left", exp_q.size(), 0);
        chk("bp_refull",  {27'd0, cnt}, 32'd16);
        rd_en = 1'b1;
        run(20);
        rd_en = 1'b0;
        chk("bp_rd_left", rb_q.size(), 0);

        // Lock hold: producer 1 pauses mid-packet while producer 3 waits
        do_reset();
        pq[1].push_back({1'b0, 8'h51}); pq[1].push_back({1'b1, 8'h52});
        pq[3].push_back({1'b1, 8'h71});
        exp_q.push_back(8'h51); exp_q.push_back(8'h52); exp_q.push_back(8'h71);
        rb_q.push_back(8'h51);  rb_q.push_back(8'h52);  rb_q.push_back(8'h71);
        run(1);
        half();
        chk("lk_grant", {30'd0, grant_id}, 32'd1);
        fin();
        hold[1] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            half();
            chk($sformatf("lk_hold_grant[%0d]", n), {30'd0, grant_id}, 32'd1);
            chk($sformatf("lk_hold_ready[%0d]", n), {28'd0, req_ready}, 32'b0010);
            chk($sformatf("lk_hold_wr[%0d]", n),    {31'd0, fifo_wr_en}, 32'd0);
            fin();
        end
        hold[1] = 1'b0;
        run(2);
        half();
        chk("lk_next_grant", {30'd0, grant_id}, 32'd3);
        chk("lk_next_wr",    {31'd0, fifo_wr_en}, 32'd1);
        fin();
        rd_en = 1'b1;
        run(6);
        rd_en = 1'b0;
        chk("lk_wr_left", exp_q.size(), 0);
        chk("lk_rd_left", rb_q.size(), 0);

        // Reset mid-burst after a grant that moved rr_ptr to 3
        do_reset();
        pq[2].push_back({1'b1, 8'h81});
        exp_q.push_back(8'h81); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        exp_q.push_back(8'h63); exp_q.push_back(8'h91);
        run(2);
        pq[0].push_back({1'b0, 8'h61}); pq[0].push_back({1'b0, 8'h62}); pq[0].push_back({1'b1, 8'h63});
        run(2);
        rst = 1'b1;
        pq[3].push_back({1'b1, 8'h91});
        half();
        chk("mr_rst_wr",    {31'd0, fifo_wr_en}, 32'd0);
        chk("mr_rst_ready", {28'd0, req_ready}, 32'd0);
        fin();
        rst = 1'b0;
        half();
        chk("mr_busy",  {31'd0, busy}, 32'd0);
        chk("mr_wr",    {31'd0, fifo_wr_en}, 32'd0);
        chk("mr_grant", {30'd0, grant_id}, 32'd0);
        fin();
        rb_q.push_back(8'h62); rb_q.push_back(8'h63); rb_q.push_back(8'h91);
        half();
        chk("mr_restart_grant", {30'd0, grant_id}, 32'd0);
        chk("mr_restart_data",  {24'd0, fifo_data_in}, 32'h62);
        fin();
        run(5);
        chk("mr_wr_left", exp_q.size(), 0);
        rd_en = 1'b1;
        run(6);
        rd_en = 1'b0;
        chk("mr_rd_left", rb_q.size(), 0);

        // NUM_REQ=3 instance: pointer wrap 2->0 and late producer 0
        do_reset();
        foreach (tv3[n]) begin
            v3 = tv3[n].valid;
            half();
            chk($sformatf("w3_busy[%0d]", n), {31'd0, busy3}, {31'd0, tv3[n].busy});
            if (tv3[n].busy) chk($sformatf("w3_grant[%0d]", n), {30'd0, g3}, {30'd0, tv3[n].grant});
            chk($sformatf("w3_wr[%0d]", n),    {31'd0, wr3}, {31'd0, tv3[n].wr});
            chk($sformatf("w3_ready[%0d]", n), {29'd0, ready3}, {29'd0, tv3[n].ready});
            chk($sformatf("w3_fd[%0d]", n),    {24'd0, fd3}, {24'd0, tv3[n].fd});
            fin();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one sync_fifo write port between NUM_REQ producers. Each producer offers a valid/ready beat stream with a last marker. The arbiter locks the FIFO to one producer for a burst, bounded by MAX_BURST beats or by req_last, and forwards beats to fifo_wr_en/fifo_data_in under fifo_full backpressure. It sits directly in front of sync_fifo's wr_en/data_in/full pins.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_WIDTH, 8, beat width; matches the sync_fifo DATA_WIDTH
MAX_BURST, 4, maximum beats per grant before forced rotation (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  NUM_REQ  per-producer beat valid
req_data  input  NUM_REQ*DATA_WIDTH  packed beats; producer i occupies [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  per-producer last-beat-of-packet marker
req_ready  output  NUM_REQ  per-producer accept; at most one bit high
fifo_full  input  1  from sync_fifo full
fifo_wr_en  output  1  to sync_fifo wr_en
fifo_data_in  output  DATA_WIDTH  to sync_fifo data_in
grant_id  output  $clog2(NUM_REQ)  index of the locked producer; valid while busy=1
busy  output  1  high while in LOCKED

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset (sampled at the clk edge) forces the following: state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0. With busy=0, req_ready=0 and fifo_wr_en=0.
- Reset mid-burst: the burst is abandoned and no write occurs in the reset cycle. The producer must re-present the beat.
- States are IDLE and LOCKED.
- IDLE:
  - req_ready=0 and fifo_wr_en=0.
  - If any req_valid bit is set, pick the first set index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register the pick into grant_id, clear beat_cnt, go to LOCKED.
  - The request is sampled in IDLE and the first beat can transfer in the next cycle, so grant latency is 1 cycle.
- LOCKED, with g = grant_id:
  - req_ready[g] = !fifo_full. All other ready bits are 0.
  - fifo_wr_en = req_valid[g] & req_ready[g]. This is combinational, with no register stage.
  - fifo_data_in = req_data slice g, always driven while LOCKED. It is 0 in IDLE.
  - On a transfer, beat_cnt increments.
  - The burst ends on a transfer with req_last[g]=1, or on a transfer that brings beat_cnt to MAX_BURST.
  - At burst end: rr_ptr <= (g+1) mod NUM_REQ, state <= IDLE. Every burst therefore costs a 1-cycle IDLE bubble.
  - req_valid[g]=0 while LOCKED: the lock is held with no timeout, which preserves packet integrity. beat_cnt holds.
  - fifo_full=1: ready=0, no write, beat_cnt and state hold. The write resumes the cycle full deasserts.
- Arbitration rules:
  - Requests arriving during LOCKED are not considered until the next IDLE.
  - Fairness: every continuously requesting producer is granted within NUM_REQ grants.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr and grant_id wrap from NUM_REQ-1 to 0. For a non-power-of-2 NUM_REQ, wrap by compare, not by overflow.
- The arbiter never drives fifo_wr_en while fifo_full=1, so no overflow is possible through this block.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (ST_IDLE, ST_LOCKED)
  - the localparams IDX_W = $clog2(NUM_REQ) and CNT_W
- One sub-module, rr_pick:
  - combinational rotating-priority picker
  - inputs: req vector, start pointer
  - outputs: found flag, index
- Top-level fifo_wr_arbiter holds the FSM, the counters and the muxing.
- The verification bench instantiates fifo_wr_arbiter feeding sync_fifo (DEPTH=16) and checks read-side order.

Test Plan:
- Single producer: req0 sends 3 beats 0x11, 0x12, 0x13 (last on 0x13), fifo empty -> grant_id=0 one cycle after valid; fifo_wr_en high 3 cycles with 0x11, 0x12, 0x13; busy drops; rr_ptr=1; FIFO reads back 0x11, 0x12, 0x13.
- Round-robin: all 4 producers valid continuously, no last, MAX_BURST=4 -> grants in order 0,1,2,3,0; each burst exactly 4 writes; 1 IDLE cycle between bursts; 16 writes fill the FIFO (full=1).
- Backpressure: FIFO pre-filled to 15 entries, req2 sends 3 beats -> 1 write, then full=1 and req_ready[2]=0, beat_cnt holds at 1; drain 2 entries via rd_en -> remaining 2 beats written in order with no loss or duplication.
- Lock hold: req1 granted, sends 1 beat, drops valid for 5 cycles while req3 is valid -> grant stays 1, req_ready[3]=0, no writes; req1 resumes with last -> then req3 is granted.
- Reset mid-burst: rst asserted for one cycle during req0's 2nd beat -> next cycle busy=0, fifo_wr_en=0, grant_id=0; the beat is not written; after release, arbitration restarts from rr_ptr=0.
- Wrap/pointer: NUM_REQ=3 build, only req2 valid with single-beat packets -> consecutive grants to 2 with rr_ptr wrapping 2->0; req0 raised later wins at the next IDLE.
